loteria_multi: RTL and testbench

//  Parametrised lottery ticket checker: latches an N-digit drawn number, accepts one

---
 rtl/loteria_multi_if.sv | 27 ++
 rtl/loteria_multi.sv | 90 +++++++++
 tb/tb_loteria_multi.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/loteria_multi_if.sv
// loteria_multi_if: ticket entry strobes, drawn number and prize outputs of the lottery checker
interface loteria_multi_if #(
  parameter int N_DIGITS = 5,
  parameter int DIGIT_W  = 4,
  parameter int COUNT_W  = 5
);
  logic [N_DIGITS*DIGIT_W-1:0] sorteio;
  logic                        novo_jogo;
  logic [DIGIT_W-1:0]          numero;
  logic                        insere;
  logic                        fim_jogo;
  logic                        fim;
  logic [1:0]                  premio;
  logic                        premio_ok;
  logic                        ocupado;
  logic [COUNT_W-1:0]          p1;
  logic [COUNT_W-1:0]          p2;
  logic [COUNT_W-1:0]          p3;
  modport master (
    output sorteio, novo_jogo, numero, insere, fim_jogo, fim,
    input  premio, premio_ok, ocupado, p1, p2, p3
  );
  modport slave (
    input  sorteio, novo_jogo, numero, insere, fim_jogo, fim,
    output premio, premio_ok, ocupado, p1, p2, p3
  );
endinterface

// File: rtl/loteria_multi.sv
// loteria_multi: grades an N-digit lottery ticket against a latched draw and keeps saturating prize tallies
module loteria_multi #(
  parameter int N_DIGITS = 5,
  parameter int DIGIT_W  = 4,
  parameter int COUNT_W  = 5,
  parameter int P2_RUN   = 3,
  parameter int P3_HITS  = 2
) (
  input logic            clock,
  input logic            reset,
  loteria_multi_if.slave bus
);
  localparam int HW = $clog2(N_DIGITS + 1);
  localparam int IW = $clog2(N_DIGITS);
  typedef enum logic [1:0] {IDLE, PLAY, FULL, GRADE} state_t;
  state_t                      st, nxt;
  logic [N_DIGITS*DIGIT_W-1:0] draw;
  logic [DIGIT_W-1:0]          dig [N_DIGITS];
  logic [IW-1:0]               idx;
  logic [HW-1:0]               hits, cur_run, max_run, run_inc;
  logic [1:0]                  grade;
  logic                        open, take, hit;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    assign dig[i] = draw[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
  end
  assign open        = (st == PLAY) || (st == FULL);
  assign take        = bus.insere && (st == PLAY) && !bus.fim_jogo;
  assign hit         = bus.numero == dig[idx];
  assign run_inc     = cur_run + 1'b1;
  assign bus.ocupado = open;
  assign grade = (hits == HW'(N_DIGITS)) ? 2'd1 :
                 (max_run >= HW'(P2_RUN)) ? 2'd2 :
                 (hits >= HW'(P3_HITS))   ? 2'd3 : 2'd0;
  always_comb begin
    nxt = bus.fim                                ? IDLE  :
          bus.novo_jogo                          ? PLAY  :
          (bus.fim_jogo && open)                 ? GRADE :
          (st == GRADE)                          ? IDLE  :
          (take && idx == IW'(N_DIGITS - 1))     ? FULL  : st;
  end
  always_ff @(posedge clock) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end
  // fim and reset clear the session; novo_jogo only restarts the ticket and keeps tallies
  always_ff @(posedge clock) begin
    if (reset) begin
      draw          <= '0;
      idx           <= '0;
      hits          <= '0;
      cur_run       <= '0;
      max_run       <= '0;
      bus.premio    <= 2'd0;
      bus.premio_ok <= 1'b0;
      bus.p1        <= '0;
      bus.p2        <= '0;
      bus.p3        <= '0;
    end else begin
      bus.premio_ok <= 1'b0;
      if (bus.fim) begin
        idx        <= '0;
        hits       <= '0;
        cur_run    <= '0;
        max_run    <= '0;
        bus.premio <= 2'd0;
        bus.p1     <= '0;
        bus.p2     <= '0;
        bus.p3     <= '0;
      end else if (bus.novo_jogo) begin
        draw       <= bus.sorteio;
        idx        <= '0;
        hits       <= '0;
        cur_run    <= '0;
        max_run    <= '0;
        bus.premio <= 2'd0;
      end else if (st == GRADE) begin
        bus.premio    <= grade;
        bus.premio_ok <= 1'b1;
        bus.p1        <= bus.p1 + COUNT_W'(grade == 2'd1 && !(&bus.p1));
        bus.p2        <= bus.p2 + COUNT_W'(grade == 2'd2 && !(&bus.p2));
        bus.p3        <= bus.p3 + COUNT_W'(grade == 2'd3 && !(&bus.p3));
      end else if (take) begin
        idx     <= idx + 1'b1;
        hits    <= hit ? hits + 1'b1 : hits;
        cur_run <= hit ? run_inc : '0;
        max_run <= (hit && run_inc > max_run) ? run_inc : max_run;
      end
    end
  end
endmodule

// File: tb/tb_loteria_multi.sv
// tb_loteria_multi: scoreboard bench driving a default-width and a 2-bit-tally checker in lockstep
module tb_loteria_multi;
  localparam int N = 5;
  localparam int W = 4;
  typedef struct {int pr; int a; int b; int c; int a2; int b2; int c2;} exp_t;
  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;
  loteria_multi_if #(.N_DIGITS(N), .DIGIT_W(W), .COUNT_W(5)) b ();
  loteria_multi_if #(.N_DIGITS(N), .DIGIT_W(W), .COUNT_W(2)) s ();
  assign s.sorteio   = b.sorteio;
  assign s.novo_jogo = b.novo_jogo;
  assign s.numero    = b.numero;
  assign s.insere    = b.insere;
  assign s.fim_jogo  = b.fim_jogo;
  assign s.fim       = b.fim;
  loteria_multi #(.N_DIGITS(N), .DIGIT_W(W), .COUNT_W(5)) dut  (.clock(clock), .reset(reset), .bus(b.slave));
  loteria_multi #(.N_DIGITS(N), .DIGIT_W(W), .COUNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(s.slave));
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [N*W-1:0] m_draw;
  int m_idx, m_hits, m_cur, m_max, m_prem;
  int m_t[3];
  int m_t2[3];
  bit m_open;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_model();
    m_open = 0;
    m_prem = 0;
    for (int i = 0; i < 3; i++) begin
      m_t[i]  = 0;
      m_t2[i] = 0;
    end
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    clear_model();
    check("rst_premio", b.premio, 0);
    check("rst_ok", b.premio_ok, 0);
    check("rst_ocupado", b.ocupado, 0);
    check("rst_p1", b.p1, 0);
    check("rst_p2", b.p2, 0);
    check("rst_p3", b.p3, 0);
  endtask
  task automatic new_ticket();
    b.novo_jogo = 1;
    step();
    b.novo_jogo = 0;
    m_draw = b.sorteio;
    m_open = 1;
    m_idx = 0;
    m_hits = 0;
    m_cur = 0;
    m_max = 0;
    m_prem = 0;
    check("open_ocupado", b.ocupado, 1);
    check("open_premio", b.premio, 0);
  endtask
  task automatic ins(input int d);
    logic [W-1:0] want;
    b.numero = W'(d);
    b.insere = 1;
    step();
    b.insere = 0;
    if (m_open && m_idx < N) begin
      want = m_draw[(N-1-m_idx)*W +: W];
      if (want == W'(d)) begin
        m_hits++;
        m_cur++;
        if (m_cur > m_max) m_max = m_cur;
      end else m_cur = 0;
      m_idx++;
    end
  endtask
  task automatic ins_list(input int d0, input int d1, input int d2, input int d3, input int d4);
    ins(d0); ins(d1); ins(d2); ins(d3); ins(d4);
  endtask
  task automatic close(input bit with_ins, input int d);
    exp_t e;
    b.fim_jogo = 1;
    b.insere = with_ins;
    b.numero = W'(d);
    step();
    b.fim_jogo = 0;
    b.insere = 0;
    if (m_open) begin
      m_prem = (m_hits == N) ? 1 : (m_max >= 3) ? 2 : (m_hits >= 2) ? 3 : 0;
      if (m_prem != 0) begin
        if (m_t[m_prem-1] < 31) m_t[m_prem-1]++;
        if (m_t2[m_prem-1] < 3) m_t2[m_prem-1]++;
      end
      e = '{m_prem, m_t[0], m_t[1], m_t[2], m_t2[0], m_t2[1], m_t2[2]};
      sb.push_back(e);
      m_open = 0;
    end
    step();
    step();
  endtask
  task automatic end_session(input bit with_new);
    b.fim = 1;
    b.novo_jogo = with_new;
    step();
    b.fim = 0;
    b.novo_jogo = 0;
    clear_model();
    check("fim_ocupado", b.ocupado, 0);
    check("fim_premio", b.premio, 0);
    check("fim_p1", b.p1, 0);
    check("fim_p2", b.p2, 0);
    check("fim_p3", b.p3, 0);
  endtask
  always @(negedge clock) begin
    if (!reset && b.premio_ok === 1'b1) begin
      if (sb.size() == 0) check("unexpected_ok", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("premio", b.premio, e.pr);
        check("p1", b.p1, e.a);
        check("p2", b.p2, e.b);
        check("p3", b.p3, e.c);
        check("p1_w2", s.p1, e.a2);
        check("p2_w2", s.p2, e.b2);
        check("p3_w2", s.p3, e.c2);
        check("ok_lockstep", s.premio_ok, 1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  initial begin
    b.sorteio = 20'h53820;
    b.novo_jogo = 0;
    b.numero = 0;
    b.insere = 0;
    b.fim_jogo = 0;
    b.fim = 0;
    do_reset();
    new_ticket(); ins_list(5, 3, 8, 2, 0);
    check("full_ocupado", b.ocupado, 1);
    close(0, 0);
    step(); step();
    check("premio_hold", b.premio, 1);
    check("idle_ocupado", b.ocupado, 0);
    new_ticket(); ins_list(5, 3, 8, 7, 7); close(0, 0);
    new_ticket(); ins_list(5, 9, 8, 9, 0); close(0, 0);
    new_ticket(); ins_list(1, 1, 1, 1, 1); close(0, 0);
    new_ticket(); ins(5); ins(3); ins(8); close(0, 0);
    new_ticket(); ins_list(5, 3, 8, 2, 0); ins(9); ins(9); close(0, 0);
    new_ticket();
    b.sorteio = 20'hFFFFF;
    ins_list(5, 3, 8, 2, 0); close(0, 0);
    b.sorteio = 20'h53820;
    close(0, 0);
    new_ticket(); ins_list(5, 3, 8, 2, 0); close(0, 0);
    check("sat_p1_w2", s.p1, 3);
    check("p1_w5", b.p1, 4);
    new_ticket(); ins(5); ins(3); close(1, 8);
    new_ticket(); ins(5); ins(3);
    end_session(0);
    new_ticket(); ins(5);
    end_session(1);
    new_ticket(); ins_list(5, 3, 8, 2, 0); close(0, 0);
    check("after_fim_p1", b.p1, 1);
    new_ticket(); ins(5);
    do_reset();
    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
